// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage core: Tuse/Tnew dependency stalls plus md-unit occupancy.
// Define HAZARD_MD_EN to build the multiply/divide busy tracker; without it the block is purely dependency-based.
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_tuse_rs,
   input  logic [1:0] D_tuse_rt,
   input  logic       D_is_md,
   input  logic [4:0] E_wa,
   input  logic [4:0] M_wa,
   input  logic [1:0] E_tnew,
   input  logic [1:0] M_tnew,
   input  logic       E_md_start,
   input  logic       E_md_div,
   output logic       PC_EN,
   output logic       FD_EN,
   output logic       DE_clr,
   output logic       md_busy
);

   // An operand stalls when a pending writer will not have its result ready before D needs it.
   function automatic logic dep_stall(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] e_wa,
      input logic [1:0] e_tnew,
      input logic [4:0] m_wa,
      input logic [1:0] m_tnew
   );
      logic used;
      used = (tuse != 2'd3) && (src != 5'd0);
      return used && (((src == e_wa) && (e_tnew > tuse)) ||
                      ((src == m_wa) && (m_tnew > tuse)));
   endfunction

   logic rs_stall;
   logic rt_stall;
   logic md_stall;
   logic stall;

   assign rs_stall = dep_stall(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
   assign rt_stall = dep_stall(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);

`ifdef HAZARD_MD_EN
   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW      = (MAX_CYC < 16) ? 4 : $clog2(MAX_CYC + 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   md_state_t     state;
   md_state_t     state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // A start seen while BUSY is a protocol violation and is dropped without reloading.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (E_md_start) begin
               cnt_next   = E_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt > CW'(1)) begin
               cnt_next = cnt - CW'(1);
            end else begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign md_busy  = (state == BUSY);
   assign md_stall = ~reset & D_is_md & (md_busy | E_md_start);
`else
   logic unused_md_inputs;
   assign unused_md_inputs = ^{clk, reset, D_is_md, E_md_start, E_md_div};
   assign md_busy  = 1'b0;
   assign md_stall = 1'b0;
`endif

   assign stall  = rs_stall | rt_stall | md_stall;
   assign PC_EN  = ~stall;
   assign FD_EN  = ~stall;
   assign DE_clr = stall;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It decides each cycle whether the PC and F/D pipeline register hold (EN low) and whether a bubble is inserted into D/E. It uses register-dependency timing (Tuse/Tnew) and tracks the multi-cycle multiply/divide unit with an internal busy state machine. It sits beside the decode stage and drives the PC register enable, the F/D register `EN`, and the D/E register clear.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu issues.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu issues.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `D_rs`, `D_rt`  in  5 each  source register numbers of the instruction in D.
- `D_tuse_rs`, `D_tuse_rt`  in  2 each  cycles until D needs the operand: 0, 1 or 2; 3 means the operand is unused.
- `D_is_md`  in  1  D instruction touches HI/LO or the md unit (mult/div/mfhi/mflo/mthi/mtlo).
- `E_wa`, `M_wa`  in  5 each  destination registers in E and M; 0 means no write.
- `E_tnew`, `M_tnew`  in  2 each  cycles until the E/M result is available, 0..2.
- `E_md_start`  in  1  the E instruction is mult/multu/div/divu this cycle.
- `E_md_div`  in  1  qualifies `E_md_start`: 1 = divide, 0 = multiply.
- `PC_EN`  out  1  PC register write enable.
- `FD_EN`  out  1  F/D register enable.
- `DE_clr`  out  1  D/E register flush (bubble).
- `md_busy`  out  1  md unit is computing.

## Operation
- Dependency stall on rs (rt is identical with `D_rt`/`D_tuse_rt`):
  - Condition: `D_tuse_rs != 3` and `D_rs != 0`.
  - And either (`D_rs == E_wa` and `E_tnew > D_tuse_rs`) or (`D_rs == M_wa` and `M_tnew > D_tuse_rs`).
  - Compares are unsigned 2-bit.
- md stall: `D_is_md` and (`md_busy` or `E_md_start`).
- `stall` = rs stall OR rt stall OR md stall.
- Outputs: `PC_EN = FD_EN = ~stall`; `DE_clr = stall`. All are combinational from the current inputs and state.
- md state machine, states IDLE and BUSY, with a 4-bit down-counter `cnt` (width ≥ clog2 of the larger parameter):
  - IDLE, `E_md_start`=1: load `cnt` = `DIV_CYCLES` if `E_md_div` else `MULT_CYCLES`; go to BUSY.
  - IDLE, otherwise: stay.
  - BUSY, `cnt` > 1: decrement.
  - BUSY, `cnt` == 1: set `cnt` to 0 and go to IDLE.
  - BUSY, `E_md_start`=1: protocol violation. Ignore it, with no reload. It cannot occur because the md stall blocks issue.
- `md_busy` = (state == BUSY).
- Write register 0 never causes a stall.

## Timing
- Reset (synchronous): state IDLE, `cnt` 0, `md_busy` 0 from the first edge with `reset` high.
- Reset mid-operation: BUSY is aborted and the block is IDLE after that edge.
- While `reset` is high, `PC_EN`/`FD_EN`/`DE_clr` still follow the dependency terms. The md term is 0 once reset has been sampled.
- `md_busy` rises the cycle after `E_md_start` and stays high exactly `MULT_CYCLES` or `DIV_CYCLES` cycles.
- An md instruction in D stalls from the issue cycle through the last busy cycle. It proceeds on the first cycle with `md_busy` low.
- Dependency stalls are zero-latency: they assert in the same cycle the hazard is present.
- A load-use hazard costs exactly one stall cycle: E_tnew=2 with D_tuse=1 stalls, then M_tnew=1 with D_tuse=1 clears.
- Simultaneous dependency and md stall produce a single `stall`. There is no double counting.

## Configuration
- Macro `HAZARD_MD_EN`.
- Defined: md state machine, `md_busy` and the md stall term are present as described.
- Undefined:
  - No state registers.
  - `md_busy` is tied to 0.
  - The md stall term is 0.
  - `E_md_start`, `E_md_div` and `D_is_md` are ignored.
  - The block is purely dependency-based, for cores without a HI/LO unit.

## Test plan
- Load-use on rs: D `D_rs`=8, `D_tuse_rs`=1; E `E_wa`=8, `E_tnew`=2. Expect `PC_EN`=0, `FD_EN`=0, `DE_clr`=1 for one cycle. Next cycle, `M_wa`=8, `M_tnew`=1: no stall.
- Register 0 and unused operand: `D_rs`=0 with `E_wa`=0, `E_tnew`=2 → no stall. `D_tuse_rt`=3 with `D_rt`=`E_wa`=9 → no stall.
- Multiply occupancy, default parameters: pulse `E_md_start`=1, `E_md_div`=0. Expect `md_busy` high exactly 5 cycles. Hold `D_is_md`=1 throughout: stall in the issue cycle plus 5 busy cycles, then release.
- Divide occupancy: `E_md_div`=1. Expect `md_busy` high exactly 10 cycles. A non-md instruction in D (`D_is_md`=0) never stalls during this time.
- Reset mid-divide: assert `reset` at busy cycle 4. Expect `md_busy`=0 after that edge, and a new multiply afterwards busy for exactly 5 cycles.
- Simultaneous hazards: `D_is_md`=1 while `md_busy`, plus an rt load-use. Expect a single `DE_clr`=1 per cycle; release only when both conditions clear.
